// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: in-order instruction prefetch buffer with flush discard accounting
module instr_fetch_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ready,
    output logic              err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_out;
    logic [CW-1:0]     r_disc;
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [PW-1:0]     r_twp;
    logic [PW-1:0]     r_trp;
    logic [ADDR_W-1:0] r_tag [DEPTH];
    logic [ADDR_W-1:0] r_fa  [DEPTH];
    logic [DATA_W-1:0] r_fd  [DEPTH];
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_err;

    logic              w_accept;
    logic              w_rsp;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_sum;
    logic [CW-1:0]     w_out_rsp;
    logic [CW-1:0]     w_disc_rsp;

    // Occupancy is buffered words plus words still owed by memory, so a full
    // pipeline can never overrun the FIFO.
    assign w_sum      = r_count + r_out;
    assign pc_ready   = (r_state == RUN) && !flush && (w_sum < CW'(DEPTH));
    assign w_accept   = pc_valid && pc_ready;
    assign w_rsp      = mem_rvalid && (r_out != '0);
    assign w_drop     = w_rsp && (r_disc != '0);
    assign w_push     = w_rsp && (r_disc == '0) && !flush;
    assign w_pop      = inst_valid && inst_ready && !flush;
    assign w_out_rsp  = r_out - CW'(w_rsp);
    assign w_disc_rsp = r_disc - CW'(w_drop);

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign inst_valid = (r_count != '0);
    assign inst_data  = r_fd[r_rp];
    assign inst_addr  = r_fa[r_rp];
    assign err        = r_err;

    // Request issue, response routing, FIFO bookkeeping and RUN/FLUSH control.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= RUN;
            r_count    <= '0;
            r_out      <= '0;
            r_disc     <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_twp      <= '0;
            r_trp      <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fa[i] <= '0;
                r_fd[i] <= '0;
            end
        end else begin
            if (mem_rvalid && (r_out == '0))
                r_err <= 1'b1;
            r_mem_req <= w_accept;
            if (w_accept)
                r_mem_addr <= pc_addr;
            if (flush) begin
                r_count <= '0;
                r_wp    <= '0;
                r_rp    <= '0;
                r_twp   <= '0;
                r_trp   <= '0;
                r_out   <= w_out_rsp;
                r_disc  <= w_out_rsp;
                r_state <= (w_out_rsp != '0) ? FLUSH : RUN;
            end else begin
                r_out   <= w_out_rsp + CW'(w_accept);
                r_disc  <= w_disc_rsp;
                r_state <= (w_disc_rsp != '0) ? FLUSH : RUN;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_accept) begin
                    r_tag[r_twp] <= pc_addr;
                    r_twp        <= r_twp + 1'b1;
                end
                if (w_push) begin
                    r_fa[r_wp] <= r_tag[r_trp];
                    r_fd[r_wp] <= mem_rdata;
                    r_wp       <= r_wp + 1'b1;
                    r_trp      <= r_trp + 1'b1;
                end
                if (w_pop)
                    r_rp <= r_rp + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: vectors, directed corner cases and random traffic against a queue model
module tb_instr_fetch_buffer;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int D  = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          pc_valid;
    logic [AW-1:0] pc_addr;
    logic          pc_ready;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          flush;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_addr;
    logic          inst_ready;
    logic          err;

    always #5 CLK = ~CLK;

    instr_fetch_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
        .CLK(CLK), .RST(RST), .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_ready(pc_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .flush(flush), .inst_valid(inst_valid), .inst_data(inst_data), .inst_addr(inst_addr),
        .inst_ready(inst_ready), .err(err)
    );

    typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
    typedef struct {logic [AW-1:0] a; int due;} mreq_t;
    typedef struct {
        int pv, pa, rv, rd, ir, fl;
        int e_rdy, e_req, e_maddr, e_iv, e_ia, e_id;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc_n  = 0;

    ent_t          mf[$];
    logic [AW-1:0] mt[$];
    int            m_out, m_disc;
    logic          m_err, m_req;
    logic [AW-1:0] m_req_addr;

    mreq_t memq[$];
    bit    mem_auto;
    int    mem_lat = 2;
    int    rv_pct  = 100;
    int    last_due = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    endtask

    function automatic bit exp_ready();
        return !flush && (m_disc == 0) && (mf.size() + m_out < D);
    endfunction

    task automatic half1();
        mreq_t r;
        if (mem_auto) begin
            mem_rvalid = 1'b0;
            if (memq.size() > 0 && memq[0].due <= cyc_n && $urandom_range(99) < rv_pct) begin
                r = memq.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata = {~r.a, r.a};
            end
        end
        @(negedge CLK);
        chk("pc_ready", pc_ready, exp_ready());
        chk("mem_req", mem_req, m_req);
        if (m_req) chk("mem_addr", mem_addr, m_req_addr);
        chk("inst_valid", inst_valid, mf.size() > 0);
        if (mf.size() > 0) begin
            chk("inst_addr", inst_addr, mf[0].a);
            chk("inst_data", inst_data, mf[0].d);
        end
        chk("err", err, m_err);
        if (mem_auto && mem_req) begin
            r.a = mem_addr;
            r.due = (cyc_n + mem_lat > last_due + 1) ? cyc_n + mem_lat : last_due + 1;
            last_due = r.due;
            memq.push_back(r);
        end
    endtask

    task automatic half2();
        ent_t e;
        logic [AW-1:0] t;
        bit acc, pop;
        acc = pc_valid && exp_ready();
        pop = !flush && inst_ready && mf.size() > 0;
        if (pop) e = mf.pop_front();
        if (mem_rvalid) begin
            if (m_out == 0) m_err = 1'b1;
            else begin
                m_out--;
                if (m_disc > 0) m_disc--;
                else begin
                    t = mt.pop_front();
                    e.a = t;
                    e.d = mem_rdata;
                    if (!flush) mf.push_back(e);
                end
            end
        end
        if (flush) begin
            mf.delete();
            mt.delete();
            m_disc = m_out;
        end
        if (acc) begin
            m_out++;
            mt.push_back(pc_addr);
            m_req_addr = pc_addr;
        end
        m_req = acc;
        @(posedge CLK);
        #1;
        cyc_n++;
    endtask

    task automatic cyc();
        half1();
        half2();
    endtask

    task automatic do_reset();
        RST = 1'b1; pc_valid = 1'b0; pc_addr = '0; flush = 1'b0; inst_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        memq.delete();
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_pc_ready", pc_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_addr", inst_addr, 0);
        chk("rst_err", err, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mf.delete(); mt.delete();
        m_out = 0; m_disc = 0; m_err = 1'b0; m_req = 1'b0; m_req_addr = '0; last_due = 0;
    endtask

    task automatic drain();
        int g = 0;
        pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b1; rv_pct = 100;
        while ((memq.size() > 0 || mf.size() > 0 || mem_req) && g < 100) begin
            cyc();
            g++;
        end
        if (g >= 100) begin
            n_tot++;
            $display("FAIL drain_timeout: %0d cycles, required under 100", g);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t tv[7];
        int nw, g;
        tv[0] = '{1, 'h10, 0, 0,       0, 0, 1, 0, 0,    0, 0,    0};
        tv[1] = '{1, 'h11, 0, 0,       0, 0, 1, 1, 'h10, 0, 0,    0};
        tv[2] = '{0, 0,    0, 0,       0, 0, 1, 1, 'h11, 0, 0,    0};
        tv[3] = '{0, 0,    1, 'hA001,  0, 0, 1, 0, 0,    0, 0,    0};
        tv[4] = '{0, 0,    1, 'hA002,  1, 0, 1, 0, 0,    1, 'h10, 'hA001};
        tv[5] = '{0, 0,    0, 0,       1, 0, 1, 0, 0,    1, 'h11, 'hA002};
        tv[6] = '{0, 0,    0, 0,       0, 0, 1, 0, 0,    0, 0,    0};

        mem_auto = 1'b0;
        do_reset();

        // two fetches answered two cycles after each request
        for (int i = 0; i < 7; i++) begin
            pc_valid = tv[i].pv[0]; pc_addr = AW'(tv[i].pa);
            mem_rvalid = tv[i].rv[0]; mem_rdata = DW'(tv[i].rd);
            inst_ready = tv[i].ir[0]; flush = tv[i].fl[0];
            half1();
            chk($sformatf("tv%0d_pc_ready", i), pc_ready, tv[i].e_rdy);
            chk($sformatf("tv%0d_mem_req", i), mem_req, tv[i].e_req);
            if (tv[i].e_req != 0) chk($sformatf("tv%0d_mem_addr", i), mem_addr, tv[i].e_maddr);
            chk($sformatf("tv%0d_inst_valid", i), inst_valid, tv[i].e_iv);
            if (tv[i].e_iv != 0) begin
                chk($sformatf("tv%0d_inst_addr", i), inst_addr, tv[i].e_ia);
                chk($sformatf("tv%0d_inst_data", i), inst_data, tv[i].e_id);
            end
            half2();
        end

        // fill to DEPTH with the decoder stalled, then a fifth fetch waits for a pop
        mem_auto = 1'b1; mem_lat = 2; inst_ready = 1'b0; mem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pc_valid = 1'b1; pc_addr = AW'(8'h20 + k);
            cyc();
        end
        pc_valid = 1'b0;
        repeat (6) cyc();
        pc_valid = 1'b1; pc_addr = 8'h24;
        repeat (2) begin
            half1(); chk("full_stall", pc_ready, 0); chk("full_valid", inst_valid, 1); half2();
        end
        inst_ready = 1'b1;
        half1(); chk("stall_in_pop_cycle", pc_ready, 0); half2();
        inst_ready = 1'b0;
        half1(); chk("accept_after_pop", pc_ready, 1); half2();
        drain();

        // flush with three in flight, coinciding with the last registered mem_req
        mem_lat = 4; inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pc_valid = 1'b1; pc_addr = AW'(8'h30 + k);
            cyc();
        end
        pc_valid = 1'b0; flush = 1'b1;
        half1(); chk("flush_coincident_req", mem_req, 1); half2();
        flush = 1'b0;
        repeat (4) begin
            half1(); chk("flush_hold", pc_ready, 0); chk("flush_empty", inst_valid, 0); half2();
        end
        pc_valid = 1'b1; pc_addr = 8'h40;
        half1(); chk("flush_release", pc_ready, 1); half2();
        drain();

        // flush in the same cycle as a response, two outstanding
        mem_lat = 2; inst_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pc_valid = 1'b1; pc_addr = AW'(8'h50 + k);
            cyc();
        end
        pc_valid = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        half1(); chk("flush_rsp_hold", pc_ready, 0); half2();
        half1(); chk("run_after_drop", pc_ready, 1); chk("dropped_empty", inst_valid, 0); half2();
        drain();

        // hold two words, pop only when a word arrives, stream through pointer wrap
        inst_ready = 1'b0; nw = 0; g = 0;
        pc_valid = 1'b1; pc_addr = 8'h60;
        while (g < 200 && (mf.size() < 2 || nw < 14)) begin
            half1();
            if (mf.size() >= 2) inst_ready = mem_rvalid;
            if (pc_ready) nw++;
            half2();
            pc_addr = AW'(8'h60 + nw);
            g++;
        end
        if (g >= 200) begin
            n_tot++;
            $display("FAIL stream_timeout: %0d words, required 14", nw);
        end
        drain();

        // random traffic with occasional flushes and variable memory latency
        for (int i = 0; i < 600; i++) begin
            pc_valid = $urandom_range(1);
            pc_addr = AW'($urandom);
            inst_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(19) == 0);
            mem_lat = $urandom_range(5, 2);
            rv_pct = 70;
            cyc();
        end
        drain();

        // stray response with nothing outstanding: err sticks, FIFO untouched
        inst_ready = 1'b0; pc_valid = 1'b1; pc_addr = 8'h77; mem_lat = 2;
        cyc();
        pc_valid = 1'b0; g = 0;
        while ((memq.size() > 0 || mem_req) && g < 50) begin
            cyc();
            g++;
        end
        mem_auto = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        cyc();
        mem_rvalid = 1'b0;
        half1();
        chk("err_set", err, 1);
        chk("err_fifo_valid", inst_valid, 1);
        chk("err_fifo_addr", inst_addr, 8'h77);
        chk("err_fifo_data", inst_data, 16'h8877);
        half2();
        half1(); chk("err_sticky", err, 1); half2();
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, PC/instruction address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, maximum words in flight plus buffered; power of two, 2..16.
REQ-004 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port pc_valid  input  1  PC presents a fetch address.
REQ-007 SHALL have port pc_addr  input  ADDR_W  fetch address from PC.
REQ-008 SHALL have port pc_ready  output  1  block accepts pc_addr this cycle.
REQ-009 SHALL have port mem_req  output  1  one-cycle read strobe to instruction memory.
REQ-010 SHALL have port mem_addr  output  ADDR_W  read address, valid while mem_req=1.
REQ-011 SHALL have port mem_rvalid  input  1  memory returns one word, in request order.
REQ-012 SHALL have port mem_rdata  input  DATA_W  returned word, valid with mem_rvalid.
REQ-013 SHALL have port flush  input  1  branch taken; discard all buffered and in-flight words.
REQ-014 SHALL have port inst_valid  output  1  head instruction available.
REQ-015 SHALL have port inst_data  output  DATA_W  head instruction word.
REQ-016 SHALL have port inst_addr  output  ADDR_W  address of head instruction.
REQ-017 SHALL have port inst_ready  input  1  decoder consumes head this cycle.
REQ-018 SHALL have port err  output  1  sticky: mem_rvalid received with nothing outstanding.

Function
REQ-019 SHALL track count (FIFO words, 0..DEPTH), outstanding (issued, unanswered, 0..DEPTH) and discard (responses to drop, 0..DEPTH).
REQ-020 SHALL drive pc_ready = (state==RUN) && !flush && (count+outstanding < DEPTH), combinationally.
REQ-021 SHALL accept on pc_valid && pc_ready in cycle N: push pc_addr into the in-order address-tag queue, outstanding+1, mem_req=1 and mem_addr=pc_addr in cycle N+1 only (registered).
REQ-022 SHALL, on mem_rvalid with discard>0, drop the word and decrement discard and outstanding, without pushing to the FIFO.
REQ-023 SHALL, on mem_rvalid with discard=0 and outstanding>0, push {tag-queue head, mem_rdata} into the FIFO, pop tag, decrement outstanding.
REQ-024 SHALL, on mem_rvalid with outstanding=0, ignore the word and set err=1 until reset.
REQ-025 SHALL drive inst_valid = (count>0) and inst_data/inst_addr from FIFO head, registered storage, no combinational path from mem_rdata.
REQ-026 SHALL pop the head on inst_valid && inst_ready; simultaneous push and pop leaves count unchanged.
REQ-027 SHALL compute count+outstanding in ADDR-independent width clog2(DEPTH)+2 bits, never wrap; FIFO pointers wrap modulo DEPTH.
REQ-028 SHALL implement states RUN and FLUSH; RUN->FLUSH when flush=1 and post-flush discard>0; FLUSH->RUN when discard reaches 0; flush=1 in FLUSH restarts discard accounting identically.
REQ-029 SHALL, on flush in cycle N: empty FIFO (count=0, inst_valid=0 in N+1), set discard=outstanding (minus one if mem_rvalid also arrives in N, that word dropped), clear tag queue.
REQ-030 SHALL, when flush coincides with a registered mem_req in the same cycle, let that mem_req issue and count it in discard.
REQ-031 SHALL ignore inst_ready in the flush cycle; no pop reported.
REQ-032 SHALL hold pc_ready=0 throughout FLUSH; first post-flush accept occurs in the first RUN cycle.

Reset
REQ-033 SHALL, on RST=1 at a rising edge, set state=RUN, count=outstanding=discard=0, pointers=0, mem_req=0, inst_valid=0, err=0, mem_addr/inst_data/inst_addr=0.
REQ-034 SHALL give RST priority over flush, pc_valid, mem_rvalid and inst_ready; responses arriving after reset with nothing outstanding set err.

Verification
REQ-035 SHALL cover: reset, then pc_addr=0x10,0x11 accepted, memory answers 0xA001,0xA002 after 2 cycles -> inst_valid with (0x10,0xA001) then (0x11,0xA002), mem_req one cycle each.
REQ-036 SHALL cover: inst_ready=0, 4 addresses accepted, 4 responses -> count=4, pc_ready=0; fifth pc_valid stalls until one pop, then accepted next cycle.
REQ-037 SHALL cover: 3 outstanding, flush=1 -> inst_valid=0 next cycle, next 3 mem_rvalid dropped, pc_ready=0 for those cycles, then 0x40 accepted and returned with its data.
REQ-038 SHALL cover: flush coincident with mem_rvalid and 2 outstanding -> that word and one more dropped, RUN after second response.
REQ-039 SHALL cover: simultaneous push and pop at count=2 -> count stays 2, order preserved across pointer wrap after 10 words.
REQ-040 SHALL cover: mem_rvalid with outstanding=0 -> err=1, FIFO unchanged; RST clears err.
